stack_controller: RTL

//   Command-driven initiator for the stack port of the memory block: owns the stack pointer.

---
 rtl/stack_controller.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/stack_controller.sv
//-----------------------------------------------------------------------------
// stack_controller
//
// Command-driven initiator for the stack port of the memory block. It owns
// the stack pointer. It turns push/pop/peek/clear commands into
// stack_address / stack_value / stack_store_enable cycles. It captures
// at_stack after the memory's one-cycle registered read. Overflow and
// underflow are reported on the response and never touch memory.
//
// Every command follows the same path IDLE -> ISSUE -> WAIT -> IDLE.
//   accept edge : address / write data / write enable are registered
//   ISSUE edge  : memory performs the write or the registered read
//   WAIT edge   : at_stack is captured, depth is updated, rsp_valid is set
// A new command can be accepted while rsp_valid is high, which gives at
// most one operation every three cycles.
//
// Ports
//   clock              single clock, all state on posedge
//   reset_n            asynchronous active-low reset
//   cmd_valid/ready    command handshake (see below)
//   cmd_op             00 push, 01 pop, 10 peek, 11 clear
//   cmd_data           value to push
//   rsp_valid          one-cycle pulse, one per accepted command
//   rsp_data           popped/peeked value, 0 for push/clear/error
//   rsp_error          overflow or underflow, qualified by rsp_valid
//   stack_address      memory stack address
//   stack_value        memory write data
//   stack_store_enable memory write enable (high for at most one cycle)
//   at_stack           memory read data, valid one cycle after the address
//   depth/empty/full   current entry count and its limits
//   state_dbg          current FSM state (IDLE=0, ISSUE=1, WAIT=2)
//-----------------------------------------------------------------------------
module stack_controller #(
   parameter int                    ADDR_WIDTH  = 16,
   parameter int                    DATA_WIDTH  = 16,
   parameter logic [ADDR_WIDTH-1:0] STACK_BASE  = '0,
   parameter int                    STACK_DEPTH = 256,
   parameter int                    DW          = $clog2(STACK_DEPTH + 1)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_error,
   output logic [ADDR_WIDTH-1:0] stack_address,
   output logic [DATA_WIDTH-1:0] stack_value,
   output logic                  stack_store_enable,
   input  logic [DATA_WIDTH-1:0] at_stack,
   output logic [DW-1:0]         depth,
   output logic                  empty,
   output logic                  full,
   output logic [1:0]            state_dbg
);

   // Handshake: a command transfers on a rising clock edge where cmd_valid
   // and cmd_ready are both high; cmd_op and cmd_data are sampled only on
   // that edge. cmd_ready is low while a command is in flight, and anything
   // offered during that time is ignored. rsp_valid is a single-cycle pulse
   // with no back-pressure.

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   localparam logic [1:0] OP_PUSH  = 2'b00;
   localparam logic [1:0] OP_POP   = 2'b01;
   localparam logic [1:0] OP_PEEK  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   state_t state;
   state_t state_next;

   // Operation and error verdict held from the accept edge to the response.
   logic [1:0] op_q;
   logic       err_q;

   // Values to register on the accept edge.
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic [DATA_WIDTH-1:0] acc_value;
   logic                  acc_we;
   logic                  acc_err;

   logic accept;
   logic is_read_op;

   assign cmd_ready  = (state == ST_IDLE);
   assign accept     = cmd_ready && cmd_valid;
   assign empty      = (depth == '0);
   assign full       = (depth == DW'(STACK_DEPTH));
   assign state_dbg  = state;
   assign is_read_op = (op_q == OP_POP) || (op_q == OP_PEEK);

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (cmd_valid) state_next = ST_ISSUE;
         ST_ISSUE: state_next = ST_WAIT;
         ST_WAIT:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Decode the offered command against the current depth. Address
   // arithmetic wraps modulo 2^ADDR_WIDTH, so a stack placed near the top
   // of the address space continues at address 0.
   always_comb begin
      acc_addr  = stack_address;
      acc_value = stack_value;
      acc_we    = 1'b0;
      acc_err   = 1'b0;
      case (cmd_op)
         OP_PUSH: begin
            acc_addr  = STACK_BASE + ADDR_WIDTH'(depth);
            acc_value = cmd_data;
            acc_we    = !full;
            acc_err   = full;
         end
         OP_POP, OP_PEEK: begin
            acc_addr = STACK_BASE + ADDR_WIDTH'(depth) - ADDR_WIDTH'(1);
            acc_err  = empty;
         end
         default: ; // clear: address is left where it was
      endcase
   end

   // Datapath. The asynchronous reset also drops an in-flight write
   // immediately, and no response is produced for the aborted command.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stack_address      <= STACK_BASE;
         stack_value        <= '0;
         stack_store_enable <= 1'b0;
         rsp_valid          <= 1'b0;
         rsp_data           <= '0;
         rsp_error          <= 1'b0;
         depth              <= '0;
         op_q               <= OP_PUSH;
         err_q              <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  stack_address      <= acc_addr;
                  stack_value        <= acc_value;
                  stack_store_enable <= acc_we;
                  op_q               <= cmd_op;
                  err_q              <= acc_err;
               end
            end
            ST_ISSUE: begin
               stack_store_enable <= 1'b0;
            end
            ST_WAIT: begin
               rsp_valid <= 1'b1;
               rsp_error <= err_q;
               rsp_data  <= (is_read_op && !err_q) ? at_stack : '0;
               if (!err_q) begin
                  case (op_q)
                     OP_PUSH:  depth <= depth + DW'(1);
                     OP_POP:   depth <= depth - DW'(1);
                     OP_CLEAR: depth <= '0;
                     default:  ; // peek leaves depth alone
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule
